// File: rtl/xinitial_symbol_buffer_pkg.sv
// Detector constants package.
// Holds the default lane/alphabet/symbol geometry shared by the detector
// stages, plus the index-to-bipolar-symbol mapping used wherever argmax
// indices are turned into signed symbol values.
package xinitial_symbol_buffer_pkg;

  localparam int unsigned DEF_J      = 14;
  localparam int unsigned DEF_A      = 2;
  localparam int unsigned DEF_AWIDTH = $clog2(DEF_A) + 1;
  localparam int unsigned DEF_SWIDTH = 8;

  // Clamp the index into 0..alpha-1, then map onto the odd bipolar grid
  // -(alpha-1), -(alpha-3), ..., +(alpha-1).
  function automatic int sym_of_idx(input int unsigned idx, input int unsigned alpha);
    int unsigned c;
    c = (idx >= alpha) ? alpha - 1 : idx;
    return 2 * int'(c) - int'(alpha) + 1;
  endfunction

endpackage

// File: rtl/xinitial_symbol_buffer_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   wr_en, din  write request and data; ignored when full unless rd_en
//               frees a slot in the same cycle
//   rd_en       pop the head entry; ignored when empty
//   dout        head entry, combinational from storage (zero when empty)
//   full, empty occupancy status
//   fill        current occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill  = wr_ptr - rd_ptr;

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/xinitial_symbol_buffer.sv
// x_initial symbol buffer.
// Registers each J-lane argmax index vector, maps every lane to a signed
// bipolar symbol, buffers the vectors in a FWFT FIFO and presents them as a
// ready/valid stream with tlast marking the final vector of each frame.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   x_initial         J lane indices, lane j at [j*AWIDTH +: AWIDTH]
//   x_initial_tvalid  one-cycle qualifier, no backpressure
//   dout              J signed symbols, lane j at [j*SWIDTH +: SWIDTH]
//   dout_tvalid       FIFO non-empty
//   dout_tready       downstream accept
//   dout_tlast        last vector of a frame
//   overflow          sticky: a vector was dropped because the FIFO was full
//   range_err         sticky: a lane index was >= A
//   fill              FIFO occupancy
module xinitial_symbol_buffer
  import xinitial_symbol_buffer_pkg::*;
#(
  parameter int unsigned J         = DEF_J,
  parameter int unsigned A         = DEF_A,
  parameter int unsigned AWIDTH    = $clog2(A) + 1,
  parameter int unsigned SWIDTH    = DEF_SWIDTH,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FRAME_LEN = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [J*AWIDTH-1:0]     x_initial,
  input  logic                    x_initial_tvalid,
  output logic [J*SWIDTH-1:0]     dout,
  output logic                    dout_tvalid,
  input  logic                    dout_tready,
  output logic                    dout_tlast,
  output logic                    overflow,
  output logic                    range_err,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned DW = J * SWIDTH;

  logic [DW-1:0]  sym_c;
  logic [J-1:0]   lane_bad;
  logic [DW-1:0]  s1_data;
  logic           s1_valid;
  logic [FW-1:0]  frame_cnt;
  logic           frame_last;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_rd;
  logic           accept;
  logic [DW:0]    fifo_din;
  logic [DW:0]    fifo_dout;

  always_comb begin
    sym_c    = '0;
    lane_bad = '0;
    for (int unsigned j = 0; j < J; j++) begin
      sym_c[j*SWIDTH +: SWIDTH] = SWIDTH'(sym_of_idx(32'(x_initial[j*AWIDTH +: AWIDTH]), A));
      lane_bad[j]               = 32'(x_initial[j*AWIDTH +: AWIDTH]) >= A;
    end
  end

  // Stage 1: map register. Data only loads on a valid input so the
  // registered vector is a clean snapshot of the accepted argmax output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      s1_valid <= x_initial_tvalid;
      if (x_initial_tvalid) begin
        s1_data <= sym_c;
        if (|lane_bad) range_err <= 1'b1;
      end
    end
  end

  // A full FIFO still accepts the vector when the head is read in the same
  // cycle; only a genuine drop raises overflow and stalls the frame count.
  assign fifo_rd    = dout_tvalid && dout_tready;
  assign accept     = s1_valid && (!fifo_full || fifo_rd);
  assign frame_last = (frame_cnt == FW'(FRAME_LEN - 1));
  assign fifo_din   = {frame_last, s1_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
      end else if (s1_valid) begin
        overflow <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (s1_valid),
    .din   (fifo_din),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  assign dout_tvalid = !fifo_empty;
  assign dout        = fifo_dout[DW-1:0];
  assign dout_tlast  = fifo_dout[DW];

endmodule

// File: tb/tb_xinitial_symbol_buffer.sv
module tb_xinitial_symbol_buffer;

  localparam int J     = 14;
  localparam int A     = 2;
  localparam int AWD   = 2;
  localparam int SWD   = 8;
  localparam int DEPTH = 16;
  localparam int FL    = 7;
  localparam int DW    = J * SWD;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic               clk;
  logic               rst;
  logic [J*AWD-1:0]   x_initial;
  logic               x_initial_tvalid;
  logic [DW-1:0]      dout;
  logic               dout_tvalid;
  logic               dout_tready;
  logic               dout_tlast;
  logic               overflow;
  logic               range_err;
  logic [4:0]         fill;

  xinitial_symbol_buffer #(
    .J         (J),
    .A         (A),
    .AWIDTH    (AWD),
    .SWIDTH    (SWD),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .x_initial        (x_initial),
    .x_initial_tvalid (x_initial_tvalid),
    .dout             (dout),
    .dout_tvalid      (dout_tvalid),
    .dout_tready      (dout_tready),
    .dout_tlast       (dout_tlast),
    .overflow         (overflow),
    .range_err        (range_err),
    .fill             (fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            total;
  int            bad;
  exp_t          q[$];
  logic          s1v_m;
  logic [DW-1:0] s1d_m;
  int            fcnt_m;
  logic          ovf_m;
  logic          rerr_m;
  int            maxq;
  int            popn;
  logic [31:0]   lastmask;
  logic [DW-1:0] lastpop;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] map_vec(input logic [J*AWD-1:0] x);
    logic [DW-1:0] r;
    int idx;
    int c;
    r = '0;
    for (int j = 0; j < J; j++) begin
      idx = int'(x[j*AWD +: AWD]);
      c   = (idx >= A) ? A - 1 : idx;
      r[j*SWD +: SWD] = 8'(2 * c - (A - 1));
    end
    return r;
  endfunction

  function automatic logic any_bad(input logic [J*AWD-1:0] x);
    logic b;
    b = 1'b0;
    for (int j = 0; j < J; j++) if (int'(x[j*AWD +: AWD]) >= A) b = 1'b1;
    return b;
  endfunction

  function automatic logic [J*AWD-1:0] rand_vec();
    logic [J*AWD-1:0] v;
    for (int j = 0; j < J; j++) v[j*AWD +: AWD] = 2'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    s1v_m  = 1'b0;
    s1d_m  = '0;
    fcnt_m = 0;
    ovf_m  = 1'b0;
    rerr_m = 1'b0;
  endtask

  // One clock: compare and advance the reference model at the falling edge,
  // then return just after the next rising edge for the caller to drive.
  task automatic tick();
    logic rd;
    logic wr;
    exp_t e;
    @(negedge clk);
    if (rst) model_reset();
    check("tvalid", 128'(dout_tvalid), 128'(q.size() != 0));
    check("fill", 128'(fill), 128'(q.size()));
    check("overflow", 128'(overflow), 128'(ovf_m));
    check("range_err", 128'(range_err), 128'(rerr_m));
    if (!rst) begin
      rd = (q.size() != 0) && dout_tready;
      if (rd) begin
        e = q.pop_front();
        check("dout", 128'(dout), 128'(e.data));
        check("tlast", 128'(dout_tlast), 128'(e.last));
        if (popn < 32) lastmask[popn] = dout_tlast;
        popn++;
        lastpop = dout;
      end
      wr = s1v_m && (q.size() < DEPTH);
      if (wr) begin
        e.data = s1d_m;
        e.last = (fcnt_m == FL - 1);
        q.push_back(e);
        fcnt_m = (fcnt_m == FL - 1) ? 0 : fcnt_m + 1;
      end else if (s1v_m) begin
        ovf_m = 1'b1;
      end
      if (q.size() > maxq) maxq = q.size();
      if (x_initial_tvalid) begin
        s1d_m = map_vec(x_initial);
        if (any_bad(x_initial)) rerr_m = 1'b1;
      end
      s1v_m = x_initial_tvalid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    x_initial_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [J*AWD-1:0] v);
    x_initial        = v;
    x_initial_tvalid = 1'b1;
    tick();
    x_initial_tvalid = 1'b0;
  endtask

  task automatic drain();
    dout_tready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || s1v_m); i++) tick();
    check("drain_empty", 128'(dout_tvalid), 128'(0));
  endtask

  initial begin
    logic [J*AWD-1:0] v;
    logic [DW-1:0]    exp1;
    total = 0;
    bad   = 0;
    maxq  = 0;
    popn  = 0;
    lastmask = '0;
    lastpop  = '0;
    rst = 1'b1;
    x_initial = '0;
    x_initial_tvalid = 1'b0;
    dout_tready = 1'b0;
    model_reset();

    // Reset state
    tick();
    check("rst_dout", 128'(dout), 128'(0));
    check("rst_tlast", 128'(dout_tlast), 128'(0));
    tick();
    rst = 1'b0;
    tick();

    // Single vector, alternating lanes, two-cycle latency
    for (int j = 0; j < J; j++) v[j*AWD +: AWD] = 2'(j % 2);
    for (int j = 0; j < J; j++) exp1[j*SWD +: SWD] = (j % 2) ? 8'h01 : 8'hFF;
    send(v);
    check("lat_t1", 128'(dout_tvalid), 128'(0));
    tick();
    check("lat_t2", 128'(dout_tvalid), 128'(1));
    check("single_dout", 128'(dout), 128'(exp1));
    check("single_tlast", 128'(dout_tlast), 128'(0));
    check("single_fill", 128'(fill), 128'(1));
    tick();
    drain();

    // Two frames back to back with ready held high
    do_reset();
    dout_tready = 1'b1;
    maxq = 0;
    popn = 0;
    lastmask = '0;
    for (int i = 0; i < 14; i++) begin
      x_initial = rand_vec();
      x_initial_tvalid = 1'b1;
      tick();
    end
    x_initial_tvalid = 1'b0;
    drain();
    check("frame_npop", 128'(popn), 128'(14));
    check("frame_mask", 128'(lastmask[13:0]), 128'(14'b10000001000000));
    check("frame_maxfill", 128'(maxq <= 2), 128'(1));

    // Overflow: 18 vectors into 16 slots with no reads
    do_reset();
    dout_tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      x_initial = rand_vec();
      x_initial_tvalid = 1'b1;
      tick();
    end
    x_initial_tvalid = 1'b0;
    tick();
    check("ovf_fill", 128'(fill), 128'(16));
    check("ovf_flag", 128'(overflow), 128'(1));
    popn = 0;
    drain();
    check("ovf_npop", 128'(popn), 128'(16));
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Full FIFO with simultaneous read and write
    do_reset();
    dout_tready = 1'b0;
    for (int i = 0; i < 16; i++) send('0);
    tick();
    check("full_fill", 128'(fill), 128'(16));
    for (int j = 0; j < J; j++) v[j*AWD +: AWD] = 2'd1;
    send(v);
    dout_tready = 1'b1;
    tick();
    dout_tready = 1'b0;
    tick();
    check("rw_fill", 128'(fill), 128'(16));
    check("rw_ovf", 128'(overflow), 128'(0));
    drain();
    check("rw_lastpop", 128'(lastpop), 128'({J{8'h01}}));

    // Out-of-range lane indices clamp to +1 and set range_err
    do_reset();
    dout_tready = 1'b0;
    v = '0;
    v[3*AWD +: AWD] = 2'd2;
    v[5*AWD +: AWD] = 2'd3;
    send(v);
    tick();
    check("range_lane3", 128'(dout[3*SWD +: SWD]), 128'(8'h01));
    check("range_lane5", 128'(dout[5*SWD +: SWD]), 128'(8'h01));
    check("range_lane0", 128'(dout[0 +: SWD]), 128'(8'hFF));
    check("range_flag", 128'(range_err), 128'(1));
    drain();
    send(rand_vec());
    drain();
    check("range_sticky", 128'(range_err), 128'(1));

    // Asynchronous reset with five entries buffered
    do_reset();
    dout_tready = 1'b0;
    send(v);
    for (int i = 0; i < 4; i++) send(rand_vec());
    tick();
    check("pre_fill", 128'(fill), 128'(5));
    check("pre_rerr", 128'(range_err), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 128'(dout_tvalid), 128'(0));
    check("arst_fill", 128'(fill), 128'(0));
    check("arst_rerr", 128'(range_err), 128'(0));
    check("arst_ovf", 128'(overflow), 128'(0));
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    popn = 0;
    lastmask = '0;
    for (int i = 0; i < 7; i++) send(rand_vec());
    drain();
    check("post_mask", 128'(lastmask[6:0]), 128'(7'b1000000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
